// File: rtl/hid_report_assembler_if.sv
// Byte-stream handshake between the USB/host byte source and the HID report assembler.
// A byte moves on a cycle where byte_valid and byte_ready are both high.
interface hid_report_assembler_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       frame_start;
    logic       byte_ready;

    modport master (output byte_in, output byte_valid, output frame_start, input byte_ready);
    modport slave  (input byte_in, input byte_valid, input frame_start, output byte_ready);
endinterface

// File: rtl/hid_report_assembler.sv
// Assembles 8-byte HID boot-protocol keyboard reports, publishes key slots 2..5 atomically
// and serializes newly pressed keys as single-cycle press events.
//
// state   | meaning
// IDLE    | waiting for a byte flagged frame_start
// COLLECT | storing bytes 1..7, watching the inter-byte timeout
// COMMIT  | one cycle: publish the report or flag rollover, build the pending-press mask
// PRESS   | emit one pending press per cycle, lowest slot first
module hid_report_assembler #(
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    hid_report_assembler_if.slave bus,
    output logic [7:0]            keycode_1_o,
    output logic [7:0]            keycode_2_o,
    output logic [7:0]            keycode_3_o,
    output logic [7:0]            keycode_4_o,
    output logic [7:0]            modifiers_o,
    output logic                  report_strobe_o,
    output logic                  press_valid_o,
    output logic [7:0]            press_code_o,
    output logic                  rollover_err_o,
    output logic                  timeout_err_o,
    output logic [CNT_W-1:0]      report_count_o
);
    localparam int unsigned     TO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, COMMIT, PRESS} state_e;

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [7:0]       frame_q [8];
    logic [7:0]       frame_d [8];
    logic [7:0]       kc_q [4];
    logic [7:0]       kc_d [4];
    logic [7:0]       mod_q, mod_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             roll_q, roll_d;
    logic [3:0]       mask_q, mask_d;
    logic             strobe_q, strobe_d;
    logic             pv_q, pv_d;
    logic [7:0]       pc_q, pc_d;
    logic             to_err_q, to_err_d;
    logic             xfer, rollover, found;
    logic [3:0]       pending;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            to_q     <= '0;
            for (int i = 0; i < 8; i++) frame_q[i] <= '0;
            for (int i = 0; i < 4; i++) kc_q[i] <= '0;
            mod_q    <= '0;
            cnt_q    <= '0;
            roll_q   <= 1'b0;
            mask_q   <= '0;
            strobe_q <= 1'b0;
            pv_q     <= 1'b0;
            pc_q     <= '0;
            to_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            to_q     <= to_d;
            frame_q  <= frame_d;
            kc_q     <= kc_d;
            mod_q    <= mod_d;
            cnt_q    <= cnt_d;
            roll_q   <= roll_d;
            mask_q   <= mask_d;
            strobe_q <= strobe_d;
            pv_q     <= pv_d;
            pc_q     <= pc_d;
            to_err_q <= to_err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        to_d     = to_q;
        frame_d  = frame_q;
        kc_d     = kc_q;
        mod_d    = mod_q;
        cnt_d    = cnt_q;
        roll_d   = roll_q;
        mask_d   = mask_q;
        strobe_d = 1'b0;
        pv_d     = 1'b0;
        pc_d     = pc_q;
        to_err_d = 1'b0;
        found    = 1'b0;
        xfer     = bus.byte_valid & bus.byte_ready;

        rollover = 1'b1;
        for (int i = 2; i < 8; i++) begin
            if (frame_q[i] != 8'h01) rollover = 1'b0;
        end
        // A slot is a new press only if its code is absent from all four currently published codes.
        for (int i = 0; i < 4; i++) begin
            pending[i] = (frame_q[i+2] != 8'h00) && (frame_q[i+2] != kc_q[0]) &&
                         (frame_q[i+2] != kc_q[1]) && (frame_q[i+2] != kc_q[2]) &&
                         (frame_q[i+2] != kc_q[3]);
        end

        case (state_q)
            IDLE: begin
                if (xfer && bus.frame_start) begin
                    frame_d[0] = bus.byte_in;
                    idx_d      = 3'd1;
                    to_d       = '0;
                    state_d    = COLLECT;
                end
            end
            COLLECT: begin
                if (xfer) begin
                    to_d = '0;
                    if (bus.frame_start) begin
                        frame_d[0] = bus.byte_in;
                        idx_d      = 3'd1;
                    end else begin
                        frame_d[idx_q] = bus.byte_in;
                        idx_d          = idx_q + 3'd1;
                        if (idx_q == 3'd7) state_d = COMMIT;
                    end
                end else if (to_q == TO_LAST) begin
                    to_err_d = 1'b1;
                    to_d     = '0;
                    idx_d    = '0;
                    state_d  = IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            COMMIT: begin
                idx_d = '0;
                if (rollover) begin
                    roll_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    for (int i = 0; i < 4; i++) kc_d[i] = frame_q[i+2];
                    mod_d    = frame_q[0];
                    cnt_d    = cnt_q + CNT_W'(1);
                    roll_d   = 1'b0;
                    strobe_d = 1'b1;
                    mask_d   = pending;
                    state_d  = (pending != 4'b0) ? PRESS : IDLE;
                end
            end
            PRESS: begin
                for (int i = 0; i < 4; i++) begin
                    if (mask_q[i] && !found) begin
                        found     = 1'b1;
                        pv_d      = 1'b1;
                        pc_d      = kc_q[i];
                        mask_d[i] = 1'b0;
                    end
                end
                if (mask_d == 4'b0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.byte_ready   = (state_q == IDLE) || (state_q == COLLECT);
    assign keycode_1_o      = kc_q[0];
    assign keycode_2_o      = kc_q[1];
    assign keycode_3_o      = kc_q[2];
    assign keycode_4_o      = kc_q[3];
    assign modifiers_o      = mod_q;
    assign report_strobe_o  = strobe_q;
    assign press_valid_o    = pv_q;
    assign press_code_o     = pc_q;
    assign rollover_err_o   = roll_q;
    assign timeout_err_o    = to_err_q;
    assign report_count_o   = cnt_q;
endmodule

// File: tb/tb_hid_report_assembler.sv
// Self-checking bench for hid_report_assembler: directed scenarios plus randomized frames
// compared against a report-level reference model.
module tb_hid_report_assembler;
    localparam int TIMEOUT = 4096;
    localparam int CNT_W   = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       kc1, kc2, kc3, kc4, mods, press_code;
    logic             strobe, press_valid, roll_err, to_err;
    logic [CNT_W-1:0] rcount;

    int checks = 0;
    int failures = 0;

    hid_report_assembler_if bus ();

    hid_report_assembler #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .reset_ni(rst_n), .bus(bus),
        .keycode_1_o(kc1), .keycode_2_o(kc2), .keycode_3_o(kc3), .keycode_4_o(kc4),
        .modifiers_o(mods), .report_strobe_o(strobe), .press_valid_o(press_valid),
        .press_code_o(press_code), .rollover_err_o(roll_err), .timeout_err_o(to_err),
        .report_count_o(rcount)
    );

    always #5 clk = ~clk;

    // Observed events, sampled away from the active edge
    logic [7:0] obs_press[$];
    int         obs_strobe = 0;
    int         obs_to = 0;

    always @(negedge clk) begin
        if (press_valid) obs_press.push_back(press_code);
        if (strobe) obs_strobe++;
        if (to_err) obs_to++;
    end

    // Reference model: published state as the keyboard report rules define it
    logic [7:0]       ref_kc [4];
    logic [7:0]       ref_mod;
    logic [CNT_W-1:0] ref_cnt;
    logic             ref_roll;
    logic [7:0]       exp_press[$];
    int               exp_strobe;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) ref_kc[i] = 8'h00;
        ref_mod = 8'h00; ref_cnt = '0; ref_roll = 1'b0;
        exp_press.delete(); exp_strobe = 0;
    endtask

    task automatic model_frame(input logic [7:0] f [8]);
        bit is_roll = 1'b1;
        bit seen;
        for (int i = 2; i < 8; i++) if (f[i] != 8'h01) is_roll = 1'b0;
        if (is_roll) begin
            ref_roll = 1'b1;
        end else begin
            for (int s = 0; s < 4; s++) begin
                seen = 1'b0;
                foreach (ref_kc[k]) if (ref_kc[k] == f[s+2]) seen = 1'b1;
                if (f[s+2] != 8'h00 && !seen) exp_press.push_back(f[s+2]);
            end
            for (int s = 0; s < 4; s++) ref_kc[s] = f[s+2];
            ref_mod = f[0];
            ref_cnt = ref_cnt + 1'b1;
            ref_roll = 1'b0;
            exp_strobe++;
        end
    endtask

    task automatic clear_obs();
        obs_press.delete(); exp_press.delete();
        obs_strobe = 0; exp_strobe = 0; obs_to = 0;
    endtask

    // Presents one byte and holds it until the block accepts it; returns 1 time unit after the transfer edge
    task automatic send_byte(input logic [7:0] b, input logic fs);
        int n = 0;
        bus.byte_in = b; bus.byte_valid = 1'b1; bus.frame_start = fs;
        @(negedge clk);
        while (!bus.byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL send_byte_ready: byte_ready stuck at %0b, required 1 within 50 cycles", bus.byte_ready);
        end
        @(posedge clk); #1;
        bus.byte_valid = 1'b0; bus.frame_start = 1'b0; bus.byte_in = 8'($urandom);
    endtask

    task automatic send_frame(input logic [7:0] f [8], input int gap_max);
        int g;
        for (int i = 0; i < 8; i++) begin
            g = (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max));
            if (g > 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
            send_byte(f[i], i == 0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        model_reset(); clear_obs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({kc1, kc2, kc3, kc4, mods, strobe, press_valid, press_code, roll_err, to_err, rcount, bus.byte_ready}
            !== {8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 16'h0, 1'b1}) begin
            failures++;
            $display("FAIL reset_state: kc=%h %h %h %h mod=%h strb=%b pv=%b pc=%h roll=%b to=%b cnt=%0d rdy=%b, required all 0 and rdy=1",
                     kc1, kc2, kc3, kc4, mods, strobe, press_valid, press_code, roll_err, to_err, rcount, bus.byte_ready);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        model_reset(); clear_obs();
    endtask

    task automatic test_single_press();
        logic [7:0] f [8] = '{8'h00, 8'h00, 8'h2C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(f, 0);
        @(negedge clk);
        checks++;
        if (bus.byte_ready !== 1'b0 || strobe !== 1'b0) begin
            failures++;
            $display("FAIL single_commit: rdy=%b strb=%b, required rdy=0 strb=0", bus.byte_ready, strobe);
        end
        @(negedge clk);
        checks++;
        if ({kc1, kc2, kc3, kc4, strobe, rcount, press_valid} !== {8'h2C, 8'h00, 8'h00, 8'h00, 1'b1, 16'd1, 1'b0}) begin
            failures++;
            $display("FAIL single_publish: kc=%h %h %h %h strb=%b cnt=%0d pv=%b, required 2c 00 00 00 1 1 0",
                     kc1, kc2, kc3, kc4, strobe, rcount, press_valid);
        end
        @(negedge clk);
        checks++;
        if (press_valid !== 1'b1 || press_code !== 8'h2C || strobe !== 1'b0) begin
            failures++;
            $display("FAIL single_press: pv=%b pc=%h strb=%b, required pv=1 pc=2c strb=0", press_valid, press_code, strobe);
        end
        repeat (3) @(negedge clk);
        model_frame(f);
        checks++;
        if (obs_press.size() != 1) begin
            failures++;
            $display("FAIL single_press_count: got %0d presses, required 1", obs_press.size());
        end
        clear_obs();
    endtask

    task automatic test_two_press();
        logic [7:0] f [8] = '{8'h00, 8'h00, 8'h2C, 8'h08, 8'h38, 8'h00, 8'h00, 8'h00};
        logic [7:0] code_a, code_b;
        logic       pv_a, pv_b, rdy_c, rdy_a, rdy_b, rdy_d;
        send_frame(f, 0);
        @(negedge clk); rdy_c = bus.byte_ready;
        @(negedge clk); rdy_a = bus.byte_ready;
        checks++;
        if ({kc1, kc2, kc3, kc4, strobe, rcount} !== {8'h2C, 8'h08, 8'h38, 8'h00, 1'b1, 16'd2}) begin
            failures++;
            $display("FAIL two_publish: kc=%h %h %h %h strb=%b cnt=%0d, required 2c 08 38 00 1 2",
                     kc1, kc2, kc3, kc4, strobe, rcount);
        end
        @(negedge clk); pv_a = press_valid; code_a = press_code; rdy_b = bus.byte_ready;
        @(negedge clk); pv_b = press_valid; code_b = press_code; rdy_d = bus.byte_ready;
        checks++;
        if ({pv_a, code_a, pv_b, code_b} !== {1'b1, 8'h08, 1'b1, 8'h38}) begin
            failures++;
            $display("FAIL two_press_seq: %b/%h then %b/%h, required 1/08 then 1/38", pv_a, code_a, pv_b, code_b);
        end
        checks++;
        if ({rdy_c, rdy_a, rdy_b, rdy_d} !== 4'b0001) begin
            failures++;
            $display("FAIL two_press_ready: ready sequence %b, required 0001", {rdy_c, rdy_a, rdy_b, rdy_d});
        end
        repeat (3) @(negedge clk);
        checks++;
        if (obs_press.size() != 2) begin
            failures++;
            $display("FAIL two_press_count: got %0d presses, required 2", obs_press.size());
        end
        model_frame(f);
        clear_obs();
    endtask

    task automatic test_rollover();
        logic [7:0] r [8] = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        logic [7:0] g [8] = '{8'h00, 8'h00, 8'h15, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(r, 2);
        model_frame(r);
        repeat (4) @(negedge clk);
        checks++;
        if ({roll_err, kc1, kc2, kc3, kc4, rcount} !== {ref_roll, ref_kc[0], ref_kc[1], ref_kc[2], ref_kc[3], ref_cnt}
            || obs_strobe != 0 || obs_press.size() != 0) begin
            failures++;
            $display("FAIL rollover_hold: roll=%b kc=%h %h %h %h cnt=%0d strobes=%0d presses=%0d, required 1 %h %h %h %h %0d 0 0",
                     roll_err, kc1, kc2, kc3, kc4, rcount, obs_strobe, obs_press.size(),
                     ref_kc[0], ref_kc[1], ref_kc[2], ref_kc[3], ref_cnt);
        end
        send_frame(g, 0);
        model_frame(g);
        repeat (4) @(negedge clk);
        checks++;
        if (roll_err !== 1'b0 || obs_strobe != 1 || kc1 !== 8'h15 || rcount !== ref_cnt) begin
            failures++;
            $display("FAIL rollover_clear: roll=%b strobes=%0d kc1=%h cnt=%0d, required 0 1 15 %0d",
                     roll_err, obs_strobe, kc1, rcount, ref_cnt);
        end
        checks++;
        if (obs_press.size() != 1 || obs_press[0] !== 8'h15) begin
            failures++;
            $display("FAIL rollover_press: got %0d presses first=%h, required 1 press of 15",
                     obs_press.size(), (obs_press.size() > 0) ? obs_press[0] : 8'hxx);
        end
        clear_obs();
    endtask

    task automatic test_timeout();
        logic [7:0] f [8] = '{8'h02, 8'h00, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        int seen_at = -1;
        int pulses = 0;
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h33, 1'b0);
        for (int k = 1; k <= TIMEOUT + 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (to_err) begin
                pulses++;
                if (seen_at < 0) seen_at = k;
            end
        end
        checks++;
        if (seen_at != TIMEOUT || pulses != 1) begin
            failures++;
            $display("FAIL timeout_pulse: first at idle cycle %0d with %0d pulses, required %0d and 1", seen_at, pulses, TIMEOUT);
        end
        checks++;
        if (bus.byte_ready !== 1'b1 || obs_strobe != 0) begin
            failures++;
            $display("FAIL timeout_discard: rdy=%b strobes=%0d, required 1 and 0", bus.byte_ready, obs_strobe);
        end
        #1;
        send_byte(8'h77, 1'b0);
        send_frame(f, 1);
        model_frame(f);
        repeat (6) @(negedge clk);
        checks++;
        if ({kc1, kc2, kc3, kc4, mods, rcount} !== {ref_kc[0], ref_kc[1], ref_kc[2], ref_kc[3], ref_mod, ref_cnt}
            || obs_strobe != 1 || obs_press.size() != exp_press.size()) begin
            failures++;
            $display("FAIL timeout_recover: kc=%h %h %h %h mod=%h cnt=%0d strobes=%0d presses=%0d, required %h %h %h %h %h %0d 1 %0d",
                     kc1, kc2, kc3, kc4, mods, rcount, obs_strobe, obs_press.size(),
                     ref_kc[0], ref_kc[1], ref_kc[2], ref_kc[3], ref_mod, ref_cnt, exp_press.size());
        end
        clear_obs();
    endtask

    task automatic test_restart();
        logic [7:0] f [8] = '{8'h01, 8'h00, 8'h2C, 8'h07, 8'h00, 8'h09, 8'h00, 8'h00};
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h60, 1'b0);
        send_byte(8'h61, 1'b0);
        send_frame(f, 1);
        model_frame(f);
        repeat (7) @(negedge clk);
        checks++;
        if ({kc1, kc2, kc3, kc4, mods, rcount} !== {ref_kc[0], ref_kc[1], ref_kc[2], ref_kc[3], ref_mod, ref_cnt}
            || obs_strobe != 1 || obs_to != 0) begin
            failures++;
            $display("FAIL restart_publish: kc=%h %h %h %h mod=%h cnt=%0d strobes=%0d timeouts=%0d, required %h %h %h %h %h %0d 1 0",
                     kc1, kc2, kc3, kc4, mods, rcount, obs_strobe, obs_to,
                     ref_kc[0], ref_kc[1], ref_kc[2], ref_kc[3], ref_mod, ref_cnt);
        end
        checks++;
        if (obs_press != exp_press) begin
            failures++;
            $display("FAIL restart_presses: got %p, required %p", obs_press, exp_press);
        end
        clear_obs();
    endtask

    task automatic test_reset_in_press();
        logic [7:0] f [8] = '{8'h00, 8'h00, 8'h50, 8'h51, 8'h52, 8'h00, 8'h00, 8'h00};
        int stray = 0;
        send_frame(f, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({kc1, kc2, kc3, kc4, press_valid, rcount, bus.byte_ready} !== {8'h0, 8'h0, 8'h0, 8'h0, 1'b0, 16'h0, 1'b1}) begin
            failures++;
            $display("FAIL reset_in_press: kc=%h %h %h %h pv=%b cnt=%0d rdy=%b, required 00 00 00 00 0 0 1",
                     kc1, kc2, kc3, kc4, press_valid, rcount, bus.byte_ready);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (press_valid) stray++;
        end
        checks++;
        if (stray != 0 || obs_press.size() != 0) begin
            failures++;
            $display("FAIL reset_abort_press: %0d presses after reset, required 0", obs_press.size());
        end
        model_reset(); clear_obs();
    endtask

    function automatic logic [7:0] rand_code();
        case ($urandom_range(0, 9))
            0, 1, 2: return 8'h00;
            3:       return 8'h04;
            4:       return 8'h05;
            5:       return 8'h08;
            6:       return 8'h15;
            7:       return 8'h2C;
            8:       return 8'h38;
            default: return 8'($urandom_range(2, 255));
        endcase
    endfunction

    task automatic test_random_frames();
        logic [7:0] f [8];
        int s0, p0;
        for (int n = 0; n < 40; n++) begin
            f[0] = 8'($urandom); f[1] = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 2; i < 8; i++) f[i] = 8'h01;
            end else begin
                for (int i = 2; i < 8; i++) f[i] = rand_code();
            end
            s0 = obs_strobe; p0 = exp_strobe;
            send_frame(f, 3);
            model_frame(f);
            repeat (7) @(negedge clk);
            checks++;
            if ({kc1, kc2, kc3, kc4, mods, rcount, roll_err} !==
                {ref_kc[0], ref_kc[1], ref_kc[2], ref_kc[3], ref_mod, ref_cnt, ref_roll}) begin
                failures++;
                $display("FAIL random_state[%0d]: kc=%h %h %h %h mod=%h cnt=%0d roll=%b, required %h %h %h %h %h %0d %b",
                         n, kc1, kc2, kc3, kc4, mods, rcount, roll_err,
                         ref_kc[0], ref_kc[1], ref_kc[2], ref_kc[3], ref_mod, ref_cnt, ref_roll);
            end
            checks++;
            if (obs_strobe - s0 != exp_strobe - p0 || obs_press != exp_press) begin
                failures++;
                $display("FAIL random_events[%0d]: strobes=%0d presses=%p, required strobes=%0d presses=%p",
                         n, obs_strobe - s0, obs_press, exp_strobe - p0, exp_press);
            end
            obs_press.delete(); exp_press.delete();
        end
    endtask

    initial begin
        bus.byte_in = 8'h00; bus.byte_valid = 1'b0; bus.frame_start = 1'b0;
        model_reset();
        test_reset();
        test_single_press();
        test_two_press();
        test_rollover();
        test_timeout();
        test_restart();
        test_reset_in_press();
        do_reset();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
